lcd_backlight_pwm_gen: RTL
==========================

Name: lcd_backlight_pwm_gen

Overview:
Consumes the 8-bit backlight duty value written by the Nios II into the backlight PIO register and drives the LCD backlight pin with it. Prescaled 255-step PWM. Duty updates are glitch-free, applied only at period boundaries, with an optional soft ramp toward the target. Sits in the Qsys top level between the PIO out_port and the backlight pad.

Parameters:
CLK_DIV, 196, clk cycles per PWM tick, 1..65535 (50 MHz / 196 / 255 ≈ 1 kHz PWM)
RAMP_PERIODS, 4, PWM periods per one-LSB duty step; 0 = no ramp, immediate load at boundary
INVERT, 0, 1 = active-low backlight pin; XORed onto pwm_out

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  1 = PWM running; 0 = backlight off
duty_target  in  8  requested duty from PIO out_port, same clock domain, no synchroniser
pwm_out  out  1  registered backlight drive
duty_current  out  8  duty value currently applied (shadow register)
ramping  out  1  1 while duty_current != sampled target and RAMP_PERIODS > 0
period_start  out  1  one-cycle pulse when the PWM counter wraps to 0

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, reset).
- Reset values: pwm_out=INVERT, duty_current=0, ramping=0, period_start=0, prescaler=0, pwm_cnt=0, ramp_cnt=0, state=OFF.
- Prescaler: counts 0..CLK_DIV-1. tick=1 in the cycle where the count equals CLK_DIV-1; the count then wraps to 0. CLK_DIV=1 gives tick every cycle.
- pwm_cnt: 8 bits, advances on tick, range 0..254. On tick with pwm_cnt==254 (the boundary): pwm_cnt<=0 and period_start<=1 for exactly one cycle.
- Output: each cycle, pwm_out <= INVERT ^ (state!=OFF && pwm_cnt < duty_current). One-cycle latency from the counter.
  - duty 0 → constantly inactive.
  - duty 255 → constantly active.
  - duty N → active for N ticks per 255-tick period.
- Duty update: duty_target is sampled only at a boundary. Changes mid-period have no effect until the next boundary.
- RAMP_PERIODS=0: duty_current <= duty_target at every boundary.
- RAMP_PERIODS>0: ramp_cnt counts boundaries 0..RAMP_PERIODS-1. When it wraps, duty_current moves one LSB toward the sampled target, saturating at equality. Direction is re-evaluated at every step, so a target reversal mid-ramp turns the ramp around immediately.
- State machine: OFF, STEADY, RAMP_UP, RAMP_DOWN.
  - OFF → STEADY/RAMP_* on the first cycle with enable=1. Counters start from 0. duty_current starts from 0 (soft start).
  - At each boundary: state = STEADY if duty_current==target, RAMP_UP if below, RAMP_DOWN if above.
  - Any state → OFF on enable=0 in the same cycle. Prescaler, pwm_cnt and ramp_cnt are cleared to 0; duty_current is cleared to 0. pwm_out is INVERT from the next cycle.
- ramping=1 in RAMP_UP/RAMP_DOWN only.
- enable and a boundary in the same cycle: enable=0 wins, and no duty load occurs.
- Reset mid-period: all state returns to the reset values next cycle, regardless of enable.

Test Plan:
- Duty cycle: CLK_DIV=2, RAMP_PERIODS=0, enable=1, target=128 → after first boundary, pwm_out high 256 clk / low 254 clk per 510-clk period; period_start every 510 clk.
- Extremes: target=0 → pwm_out held 0 over 3 periods; target=255 → held 1, no low glitch at wrap. INVERT=1 → the same patterns inverted.
- Mid-period change: target 64→192 written at pwm_cnt=100 → current period completes at 64 ticks high; duty_current=192 on the cycle period_start asserts.
- Ramp: RAMP_PERIODS=2, duty_current=0, target=4 → duty_current 1,2,3,4 after boundaries 2,4,6,8; ramping falls with the step to 4. Target changed to 1 at duty_current=3 → steps to 2 then 1 (RAMP_DOWN).
- Disable: enable=0 mid-ramp at duty_current=50 → next cycle pwm_out=INVERT, duty_current=0, ramping=0. Re-enable with target=50 → ramps up from 0.
- Reset: reset pulsed at pwm_cnt=200 with pwm_out active → all outputs at reset values the following cycle; the period restarts from pwm_cnt=0 after release.

Source files
------------

// File: rtl/lcd_backlight_pwm_gen.sv
// LCD backlight PWM generator.
// Prescaled 255-step PWM driven by the backlight PIO duty register. The duty
// value is only ever applied at a period boundary, so the pin never sees a
// truncated or stretched pulse. When ramping is enabled, the applied duty walks
// one LSB toward the target every RAMP_PERIODS boundaries.
module lcd_backlight_pwm_gen #(
  parameter int CLK_DIV      = 196,
  parameter int RAMP_PERIODS = 4,
  parameter bit INVERT       = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] duty_target,
  output logic       pwm_out,
  output logic [7:0] duty_current,
  output logic       ramping,
  output logic       period_start
);

  typedef enum logic [1:0] {OFF, STEADY, RAMP_UP, RAMP_DOWN} state_t;

  localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);
  localparam logic [15:0] RP_M1  = (RAMP_PERIODS > 0) ? 16'(RAMP_PERIODS - 1) : 16'd0;

  state_t      state;
  logic [15:0] presc;
  logic [7:0]  pwm_cnt;
  logic [15:0] ramp_cnt;

  logic        run, tick, bnd, ramp_wrap;
  logic [7:0]  duty_nxt;
  state_t      st_bnd, st_start;

  // Counters only advance once the FSM has left OFF; the enabling cycle itself
  // just selects the starting state, so every run begins at count zero.
  assign run       = enable && (state != OFF);
  assign tick      = run && (presc == DIV_M1);
  assign bnd       = tick && (pwm_cnt == 8'd254);
  assign ramp_wrap = (ramp_cnt == RP_M1);

  // Duty and state to be loaded at the next boundary.
  always_comb begin
    duty_nxt = duty_current;
    if (RAMP_PERIODS == 0)
      duty_nxt = duty_target;
    else if (ramp_wrap) begin
      if (duty_current < duty_target)      duty_nxt = duty_current + 8'd1;
      else if (duty_current > duty_target) duty_nxt = duty_current - 8'd1;
    end
    if (duty_nxt == duty_target)     st_bnd = STEADY;
    else if (duty_nxt < duty_target) st_bnd = RAMP_UP;
    else                             st_bnd = RAMP_DOWN;
    // Soft start: duty_current is 0 on leaving OFF, so only an upward ramp
    // (or nothing) is possible.
    st_start = (RAMP_PERIODS == 0 || duty_target == 8'd0) ? STEADY : RAMP_UP;
  end

  // Prescaler, PWM counter, ramp pacing, FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= OFF;
      presc        <= '0;
      pwm_cnt      <= '0;
      ramp_cnt     <= '0;
      duty_current <= '0;
      ramping      <= 1'b0;
      period_start <= 1'b0;
      pwm_out      <= INVERT;
    end else if (!enable) begin
      // Disable wins over a coincident boundary: nothing is loaded.
      state        <= OFF;
      presc        <= '0;
      pwm_cnt      <= '0;
      ramp_cnt     <= '0;
      duty_current <= '0;
      ramping      <= 1'b0;
      period_start <= 1'b0;
      pwm_out      <= INVERT;
    end else begin
      pwm_out      <= INVERT ^ ((state != OFF) && (pwm_cnt < duty_current));
      period_start <= bnd;
      if (state == OFF) begin
        state   <= st_start;
        ramping <= (st_start != STEADY);
      end else begin
        presc <= tick ? 16'd0 : presc + 16'd1;
        if (tick)
          pwm_cnt <= (pwm_cnt == 8'd254) ? 8'd0 : pwm_cnt + 8'd1;
        if (bnd) begin
          duty_current <= duty_nxt;
          state        <= st_bnd;
          ramping      <= (st_bnd != STEADY);
          if (RAMP_PERIODS > 0)
            ramp_cnt <= ramp_wrap ? 16'd0 : ramp_cnt + 16'd1;
        end
      end
    end
  end

endmodule
